// File: rtl/a2d_rr_intf_if.sv
// -----------------------------------------------------------------------------
// a2d_rr_intf_if
// Groups the request, result, and ADC128S SPI signals of the round-robin A2D
// front end.
//   nxt        : one-cycle request to start the next conversion (to front end)
//   lft_ld     : latest left load cell result       (from front end)
//   rght_ld    : latest right load cell result      (from front end)
//   steer_pot  : latest steering pot result         (from front end)
//   batt       : latest battery result              (from front end)
//   cnv_cmplt  : one-cycle pulse on result update   (from front end)
//   SS_n       : ADC slave select, active low       (from front end)
//   SCLK       : ADC serial clock                   (from front end)
//   MOSI       : ADC serial data in                 (from front end)
//   MISO       : ADC serial data out                (to front end)
// slave  : the A2D front end itself
// master : the system/ADC side that requests conversions and drives MISO
// -----------------------------------------------------------------------------
interface a2d_rr_intf_if;
   logic        nxt;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic [11:0] steer_pot;
   logic [11:0] batt;
   logic        cnv_cmplt;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;

   modport slave (
      input  nxt,
      input  MISO,
      output lft_ld,
      output rght_ld,
      output steer_pot,
      output batt,
      output cnv_cmplt,
      output SS_n,
      output SCLK,
      output MOSI
   );

   modport master (
      output nxt,
      output MISO,
      input  lft_ld,
      input  rght_ld,
      input  steer_pot,
      input  batt,
      input  cnv_cmplt,
      input  SS_n,
      input  SCLK,
      input  MOSI
   );
endinterface

// File: rtl/a2d_rr_intf.sv
// -----------------------------------------------------------------------------
// a2d_rr_intf
// Round-robin A2D front end for the ADC128S. Each nxt pulse converts the next
// channel in the rotation left load cell -> right load cell -> steering pot ->
// battery, using two SPI frames (the ADC answers with the channel addressed in
// the previous frame) separated by a two-clock SS_n gap.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : a2d_rr_intf_if.slave (nxt, MISO in; results, cnv_cmplt, SS_n, SCLK,
//         MOSI out)
// -----------------------------------------------------------------------------
module a2d_rr_intf #(
   parameter logic [2:0] CH_LFT   = 3'd0,
   parameter logic [2:0] CH_RGHT  = 3'd4,
   parameter logic [2:0] CH_STEER = 3'd5,
   parameter logic [2:0] CH_BATT  = 3'd6
) (
   input  logic           clk,
   input  logic           rst,
   a2d_rr_intf_if.slave   bus
);

   localparam int unsigned DATA_W   = 12;
   localparam int unsigned XFER_W   = 16;
   localparam int unsigned DIV_W    = 4;
   localparam int unsigned CNT_W    = 5;
   localparam int unsigned GAP_W    = 1;
   localparam int unsigned GAP_CLKS = 2;

   localparam logic [DIV_W-1:0] DIV_LOAD = 4'b1011;
   localparam logic [DIV_W-1:0] DIV_SMPL = 4'b0111;
   localparam logic [DIV_W-1:0] DIV_SHFT = 4'b1111;

   typedef enum logic [1:0] {ST_IDLE, ST_TX_CMD, ST_GAP, ST_TX_RD} state_t;
   typedef enum logic {SPI_IDLE, SPI_XFER} spi_state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   spi_state_t          r_spi_state;
   spi_state_t          w_spi_nxt;

   logic [DIV_W-1:0]    r_div;
   logic [XFER_W-1:0]   r_shift;
   logic [CNT_W-1:0]    r_smpl_cnt;
   logic                r_miso_smpl;
   logic                r_ss_n;
   logic [GAP_W-1:0]    r_gap_cnt;
   logic [1:0]          r_ptr;
   logic                r_cnv_cmplt;
   logic [DATA_W-1:0]   r_lft;
   logic [DATA_W-1:0]   r_rght;
   logic [DATA_W-1:0]   r_steer;
   logic [DATA_W-1:0]   r_batt;

   logic [2:0]          w_chnl;
   logic [XFER_W-1:0]   w_cmd;
   logic [DATA_W-1:0]   w_resp_c;
   logic                w_start_c;
   logic                w_spi_done_c;
   logic                w_wr_c;

   // Channel addressed by the rotation pointer
   always_comb begin
      w_chnl = CH_LFT;
      case (r_ptr)
         2'd0:    w_chnl = CH_LFT;
         2'd1:    w_chnl = CH_RGHT;
         2'd2:    w_chnl = CH_STEER;
         default: w_chnl = CH_BATT;
      endcase
   end

   assign w_cmd = {2'b00, w_chnl, 11'h000};

   // Low 12 bits of the completed frame, including the bit sampled last
   assign w_resp_c = {r_shift[DATA_W-2:0], r_miso_smpl};

   // Frame ends at the SCLK fall point following the 16th MISO sample
   assign w_spi_done_c = (r_spi_state == SPI_XFER) && (r_div == DIV_SHFT) &&
                         (r_smpl_cnt == CNT_W'(XFER_W));

   // A request is ignored while the completion pulse is still high
   assign w_start_c = ((r_state == ST_IDLE) && bus.nxt && !r_cnv_cmplt) ||
                      ((r_state == ST_GAP) && (r_gap_cnt == GAP_W'(GAP_CLKS - 1)));

   assign w_wr_c = (r_state == ST_TX_RD) && w_spi_done_c;

   // Conversion sequencer state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Conversion sequencer next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_start_c)    w_state_nxt = ST_TX_CMD;
         ST_TX_CMD: if (w_spi_done_c) w_state_nxt = ST_GAP;
         ST_GAP:    if (w_start_c)    w_state_nxt = ST_TX_RD;
         ST_TX_RD:  if (w_spi_done_c) w_state_nxt = ST_IDLE;
         default:                     w_state_nxt = ST_IDLE;
      endcase
   end

   // SS_n-high gap counter between the two frames
   always_ff @(posedge clk) begin
      if (rst)                     r_gap_cnt <= '0;
      else if (r_state == ST_GAP)  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      else                         r_gap_cnt <= '0;
   end

   // SPI monarch state register
   always_ff @(posedge clk) begin
      if (rst) r_spi_state <= SPI_IDLE;
      else     r_spi_state <= w_spi_nxt;
   end

   // SPI monarch next state
   always_comb begin
      w_spi_nxt = r_spi_state;
      case (r_spi_state)
         SPI_IDLE: if (w_start_c)    w_spi_nxt = SPI_XFER;
         SPI_XFER: if (w_spi_done_c) w_spi_nxt = SPI_IDLE;
         default:                    w_spi_nxt = SPI_IDLE;
      endcase
   end

   // SPI datapath: divider, MISO sampling at SCLK rise, shifting at SCLK fall.
   // The first fall after SS_n drops does not shift so MOSI holds bit 15 for
   // the first rise. Reloading the divider on start/done keeps SCLK high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ss_n      <= 1'b1;
         r_div       <= DIV_LOAD;
         r_shift     <= '0;
         r_smpl_cnt  <= '0;
         r_miso_smpl <= 1'b0;
      end else if (w_start_c) begin
         r_ss_n      <= 1'b0;
         r_div       <= DIV_LOAD;
         r_shift     <= w_cmd;
         r_smpl_cnt  <= '0;
      end else if (w_spi_done_c) begin
         r_ss_n      <= 1'b1;
         r_div       <= DIV_LOAD;
         r_shift     <= '0;
      end else if (r_spi_state == SPI_XFER) begin
         r_div <= r_div + DIV_W'(1);
         if (r_div == DIV_SMPL) begin
            r_miso_smpl <= bus.MISO;
            r_smpl_cnt  <= r_smpl_cnt + CNT_W'(1);
         end
         if ((r_div == DIV_SHFT) && (r_smpl_cnt != '0))
            r_shift <= {r_shift[XFER_W-2:0], r_miso_smpl};
      end
   end

   // Result registers, completion pulse and rotation pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lft       <= '0;
         r_rght      <= '0;
         r_steer     <= '0;
         r_batt      <= '0;
         r_ptr       <= '0;
         r_cnv_cmplt <= 1'b0;
      end else begin
         r_cnv_cmplt <= w_wr_c;
         if (w_wr_c) begin
            case (r_ptr)
               2'd0:    r_lft   <= w_resp_c;
               2'd1:    r_rght  <= w_resp_c;
               2'd2:    r_steer <= w_resp_c;
               default: r_batt  <= w_resp_c;
            endcase
            r_ptr <= r_ptr + 2'd1;
         end
      end
   end

   assign bus.lft_ld    = r_lft;
   assign bus.rght_ld   = r_rght;
   assign bus.steer_pot = r_steer;
   assign bus.batt      = r_batt;
   assign bus.cnv_cmplt = r_cnv_cmplt;
   assign bus.SS_n      = r_ss_n;
   assign bus.SCLK      = r_div[DIV_W-1];
   assign bus.MOSI      = r_shift[XFER_W-1];

endmodule

// File: tb/tb_a2d_rr_intf.sv
// -----------------------------------------------------------------------------
// tb_a2d_rr_intf
// Self-checking bench for a2d_rr_intf with a behavioural ADC128S model that
// answers each frame with the channel addressed by the previous complete frame.
// -----------------------------------------------------------------------------
module tb_a2d_rr_intf;

   logic clk = 1'b0;
   logic rst;

   a2d_rr_intf_if u_bus ();

   a2d_rr_intf u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_bus)
   );

   always #5 clk = ~clk;

   // ADC model state
   logic [11:0] adc_val [8];
   logic        adc_miso   = 1'b0;
   logic        in_frame   = 1'b0;
   logic        prev_ss    = 1'b1;
   logic        prev_sclk  = 1'b1;
   logic [2:0]  prev_chnl  = 3'd0;
   logic [15:0] fr_cmd     = 16'h0;
   logic [15:0] fr_resp    = 16'h0;
   int          fr_rise    = 0;
   logic [15:0] cmd_q [$];
   int          rise_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_cmplt = 0;
   int n_idle_bad = 0;
   int lat_ref = 0;
   logic [11:0] m_res [4];
   int m_ptr = 0;

   assign u_bus.MISO = adc_miso;

   // ADC128S model: command in on SCLK rise, response bits out on SCLK fall
   always @(u_bus.SS_n or u_bus.SCLK) begin
      if (prev_ss === 1'b1 && u_bus.SS_n === 1'b0) begin
         in_frame = 1'b1;
         fr_cmd   = 16'h0;
         fr_rise  = 0;
         fr_resp  = {4'h5, adc_val[prev_chnl]};
         adc_miso = fr_resp[15];
      end else if (in_frame && u_bus.SS_n === 1'b1) begin
         in_frame = 1'b0;
         cmd_q.push_back(fr_cmd);
         rise_q.push_back(fr_rise);
         if (fr_rise == 16) prev_chnl = fr_cmd[13:11];
      end else if (in_frame) begin
         if (prev_sclk === 1'b0 && u_bus.SCLK === 1'b1) begin
            fr_cmd  = {fr_cmd[14:0], u_bus.MOSI};
            fr_rise = fr_rise + 1;
         end else if (prev_sclk === 1'b1 && u_bus.SCLK === 1'b0 &&
                      fr_rise > 0 && fr_rise < 16) begin
            adc_miso = fr_resp[4'(15 - fr_rise)];
         end
      end
      prev_ss   = u_bus.SS_n;
      prev_sclk = u_bus.SCLK;
   end

   always @(posedge clk) if (u_bus.cnv_cmplt === 1'b1) n_cmplt++;

   always @(negedge clk)
      if (u_bus.SS_n === 1'b1 && u_bus.SCLK !== 1'b1) n_idle_bad++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_lft"},   32'(u_bus.lft_ld),    32'(m_res[0]));
      check({tag, "_rght"},  32'(u_bus.rght_ld),   32'(m_res[1]));
      check({tag, "_steer"}, 32'(u_bus.steer_pot), 32'(m_res[2]));
      check({tag, "_batt"},  32'(u_bus.batt),      32'(m_res[3]));
   endtask

   function automatic logic [2:0] chan_of(input int p);
      case (p)
         0:       return 3'd0;
         1:       return 3'd4;
         2:       return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_res[i] = 12'h0;
      m_ptr = 0;
   endtask

   // One conversion: pulse nxt, wait for cnv_cmplt, check frames and results.
   // busy_at re-pulses nxt mid-conversion; probe pulses nxt in the cnv_cmplt cycle.
   task automatic convert(input string tag, input logic [15:0] exp_cmd, input int sel,
                          input logic [11:0] exp_val, input int busy_at, input bit probe);
      int idx0;
      int lat;
      bit ok;
      idx0 = cmd_q.size();
      ok   = 1'b0;
      u_bus.nxt = 1'b1;
      @(negedge clk);
      u_bus.nxt = 1'b0;
      lat = 1;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         lat++;
         u_bus.nxt = (busy_at > 0 && lat == busy_at);
         if (u_bus.cnv_cmplt === 1'b1) ok = 1'b1;
      end
      u_bus.nxt = 1'b0;
      check({tag, "_done"}, 32'(ok), 32'd1);
      if (lat_ref == 0) begin
         lat_ref = lat;
         check("lat_window", 32'(lat >= 500 && lat <= 600), 32'd1);
      end
      check({tag, "_lat"}, 32'(lat), 32'(lat_ref));
      check({tag, "_nframes"}, 32'(cmd_q.size() - idx0), 32'd2);
      if (cmd_q.size() >= idx0 + 2) begin
         check({tag, "_cmd0"}, 32'(cmd_q[idx0]), 32'(exp_cmd));
         check({tag, "_cmd1"}, 32'(cmd_q[idx0 + 1]), 32'(exp_cmd));
         check({tag, "_bits"}, 32'(rise_q[idx0] + rise_q[idx0 + 1]), 32'd32);
      end
      m_res[sel] = exp_val;
      check_regs(tag);
      if (probe) u_bus.nxt = 1'b1;
      @(negedge clk);
      u_bus.nxt = 1'b0;
   endtask

   // Reference conversion driven from the model's own rotation count
   task automatic model_conv(input string tag, input int busy_at, input bit probe);
      logic [2:0] ch;
      ch = chan_of(m_ptr);
      convert(tag, {2'b00, ch, 11'h000}, m_ptr, adc_val[ch], busy_at, probe);
      m_ptr = (m_ptr + 1) % 4;
   endtask

   typedef struct {
      logic [11:0] val;
      logic [15:0] exp_cmd;
      int          exp_sel;
   } vec_t;

   initial begin
      vec_t tbl [5];
      int   f0;
      int   c0;
      int   b0;
      bit   ok;

      rst = 1'b1;
      u_bus.nxt = 1'b0;
      for (int i = 0; i < 8; i++) adc_val[i] = 12'h0;
      for (int i = 0; i < 4; i++) m_res[i] = 12'h0;

      // Reset and long idle
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_regs("rst");
      check("rst_cmplt", 32'(u_bus.cnv_cmplt), 32'd0);
      check("rst_ssn",   32'(u_bus.SS_n), 32'd1);
      check("rst_sclk",  32'(u_bus.SCLK), 32'd1);
      check("rst_mosi",  32'(u_bus.MOSI), 32'd0);
      f0 = cmd_q.size(); c0 = n_cmplt; b0 = n_idle_bad;
      repeat (1000) @(negedge clk);
      check("idle_frames", 32'(cmd_q.size() - f0), 32'd0);
      check("idle_cmplt",  32'(n_cmplt - c0), 32'd0);
      check("idle_sclk",   32'(n_idle_bad - b0), 32'd0);
      check_regs("idle");

      // Single conversion
      adc_val[0] = 12'h200;
      c0 = n_cmplt;
      convert("single", 16'h0000, 0, 12'h200, 0, 1'b0);
      m_ptr = 1;
      repeat (5) @(negedge clk);
      check("single_cmplt_cnt", 32'(n_cmplt - c0), 32'd1);

      // Full rotation and wrap from a fresh reset
      do_reset(3);
      tbl[0] = '{12'h200, 16'h0000, 0};
      tbl[1] = '{12'h1FF, 16'h2000, 1};
      tbl[2] = '{12'h800, 16'h2800, 2};
      tbl[3] = '{12'h900, 16'h3000, 3};
      tbl[4] = '{12'h0C3, 16'h0000, 0};
      for (int i = 0; i < 5; i++) begin
         adc_val[tbl[i].exp_cmd[13:11]] = tbl[i].val;
         convert($sformatf("rot%0d", i), tbl[i].exp_cmd, tbl[i].exp_sel, tbl[i].val, 0, 1'b0);
      end
      m_ptr = 1;

      // Busy-ignore: second nxt 100 clks after the first
      adc_val[4] = 12'($urandom);
      f0 = cmd_q.size(); c0 = n_cmplt;
      model_conv("busy", 100, 1'b0);
      repeat (700) @(negedge clk);
      check("busy_frames", 32'(cmd_q.size() - f0), 32'd2);
      check("busy_cmplt",  32'(n_cmplt - c0), 32'd1);

      // nxt in the cnv_cmplt cycle is dropped
      adc_val[5] = 12'($urandom);
      model_conv("probe", 0, 1'b1);
      f0 = cmd_q.size();
      repeat (30) @(negedge clk);
      check("probe_ssn",    32'(u_bus.SS_n), 32'd1);
      check("probe_frames", 32'(cmd_q.size() - f0), 32'd0);

      // Reset during the battery read frame
      do_reset(3);
      check_regs("rst2");
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      model_conv("pre_a", 0, 1'b0);
      model_conv("pre_b", 0, 1'b0);
      model_conv("pre_c", 0, 1'b0);
      f0 = cmd_q.size();
      u_bus.nxt = 1'b1;
      @(negedge clk);
      u_bus.nxt = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (cmd_q.size() == f0 + 1 && u_bus.SS_n === 1'b0) ok = 1'b1;
      end
      check("abort_reach", 32'(ok), 32'd1);
      repeat (40) @(negedge clk);
      c0 = n_cmplt;
      rst = 1'b1;
      @(negedge clk);
      check("abort_ssn",  32'(u_bus.SS_n), 32'd1);
      check("abort_sclk", 32'(u_bus.SCLK), 32'd1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_res[i] = 12'h0;
      m_ptr = 0;
      repeat (600) @(negedge clk);
      check("abort_cmplt",  32'(n_cmplt - c0), 32'd0);
      check("abort_batt",   32'(u_bus.batt), 32'd0);
      check("abort_frames", 32'(cmd_q.size() - f0), 32'd2);
      if (cmd_q.size() >= f0 + 2)
         check("abort_partial", 32'(rise_q[f0 + 1] < 16), 32'd1);
      model_conv("post_rst", 0, 1'b0);

      // Back-to-back conversions with randomized ADC values
      for (int k = 0; k < 8; k++) begin
         adc_val[0] = 12'($urandom);
         adc_val[4] = 12'($urandom);
         adc_val[5] = 12'($urandom);
         adc_val[6] = 12'($urandom);
         model_conv($sformatf("b2b%0d", k), 0, 1'b0);
      end

      check("sclk_idle_high", 32'(n_idle_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
